gfmul_array_sched: RTL and testbench
====================================

// Module: gfmul_array_sched
// PURPOSE
//  Issue scheduler for the GF(2^M) systolic multiplier array.
//  - Accepts operand triples (a, b, g) on a valid/ready input port.
//  - Drives the array operand buses and its ctr start strobe at a fixed issue interval.
//  - Tracks in-flight operations over the array's fixed latency and captures each product.
//  - Returns products in order on a valid/ready output port.
//  - Credit-based issue: a result is never dropped under output backpressure.
// PARAMETERS
//  M           8   field width (bits of a, b, g, p)
//  LAT         22  cycles from arr_ctr=1 to the valid product on arr_po
//  ISSUE_GAP   8   cycles between successive arr_ctr pulses (>=1)
//  RBUF_DEPTH  4   result buffer entries (power of 2, >=2)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   asynchronous, active-low reset
//  soft_clr  in   1   synchronous flush, active-high
//  in_valid  in   1   operand triple valid
//  in_ready  out  1   scheduler can accept a triple this cycle
//  in_a      in   M   multiplicand
//  in_b      in   M   multiplier
//  in_g      in   M   field polynomial, low M bits (x^M implicit)
//  out_valid out  1   product valid
//  out_ready in   1   consumer accepts product
//  out_p     out  M   product a*b mod g
//  arr_ctr   out  1   array start strobe
//  arr_ai    out  M   array a bus
//  arr_bi    out  M   array b bus
//  arr_gi    out  M   array g bus
//  arr_po    in   M   array product bus
//  busy      out  1   any op in flight or buffered
// BEHAVIOUR
//  Reset (rst=0, async) forces all outputs and state to 0, state=IDLE:
//   in_ready=0 until the first clk edge after release, then 1.
//  FSM has three states:
//   IDLE: in_ready=credit_ok; on accept go to ISSUE.
//   ISSUE: one cycle, arr_ctr=1; if ISSUE_GAP==1 act as last GAP cycle, else go to GAP.
//   GAP: ISSUE_GAP-1 cycles, arr_ctr=0.
//    - Last GAP cycle: in_ready=credit_ok; accept -> ISSUE, else IDLE.
//    - Back-to-back throughput is 1 op per ISSUE_GAP cycles.
//  Operand hold: on accept at cycle t, operands are registered.
//   - arr_ai/bi/gi hold them stable t+1 .. t+ISSUE_GAP.
//   - arr_ctr=1 at cycle t+1 only.
//   - Operand buses read 0 while in IDLE.
//  credit_ok = (inflight_cnt + rbuf_cnt) < RBUF_DEPTH, computed from registered counts.
//  Tracking and capture:
//   - In-flight tracker is a LAT-deep valid shift register fed by arr_ctr.
//   - Tail bit=1 at cycle t+1+LAT: arr_po is pushed to the result buffer that cycle.
//   - out_valid=1, out_p=head from t+2+LAT when the buffer was empty.
//  Output port:
//   - out_p is stable while out_valid=1 and out_ready=0.
//   - Pop on out_valid&out_ready.
//   - Simultaneous push and pop in the same cycle keeps the count unchanged, with correct ordering.
//  Buffer full: cannot overflow by construction. A push with rbuf_cnt==RBUF_DEPTH is an assertion failure.
//  Pointers wrap modulo RBUF_DEPTH.
//  soft_clr=1 (synchronous, priority over accept and push):
//   - Next cycle: tracker, buffer and counts are 0, FSM=IDLE, arr_ctr=0, out_valid=0.
//   - Array outputs of flushed ops are ignored.
//  Reset mid-operation: same as soft_clr but asynchronous. No partial product ever reaches out_p.
//  busy = (state!=IDLE) | (inflight_cnt!=0) | (rbuf_cnt!=0).
//  All arithmetic is in the array. This block does no GF math, only width-M register moves.
// STRUCTURE
//  gfmul_pkg holds:
//   - M, default LAT/ISSUE_GAP constants
//   - AES_POLY=8'h1B
//   - FSM state encoding {IDLE, ISSUE, GAP}
//  Sub-module gfmul_rbuf: synchronous RBUF_DEPTH x M FIFO with count, push, pop and clr.
//  Top holds the FSM, the gap counter, the tracker shift register and the credit logic.
// TESTING
//  Bench uses a behavioural array model (LAT-cycle delayed GF multiply) on the arr_* ports.
//  1 Single op: a=57,b=83,g=1B accepted at t -> arr_ctr pulse at t+1 only; out_p=C1 at t+2+LAT.
//  2 Stream 16 random ops with out_ready=1:
//    - arr_ctr pulses exactly ISSUE_GAP apart.
//    - Products match the reference model in order (e.g. 57*13=FE).
//  3 Backpressure: out_ready=0, offer 10 ops:
//    - Exactly RBUF_DEPTH accepted, then in_ready=0.
//    - Release -> all drained in order, no loss or duplication.
//  4 Simultaneous push and pop: out_ready=1 in the cycle a result lands with rbuf_cnt=1 -> count stays 1, order kept.
//  5 soft_clr with 2 in flight and 1 buffered -> next cycle out_valid=0, busy=0; no stale products emitted over LAT+4 cycles.
//  6 rst=0 asserted mid-GAP -> all outputs 0 immediately; after release a single op (a=02,b=87,g=1B -> 15) completes correctly.

Source files
------------

// File: rtl/gfmul_pkg.sv
// Shared definitions for the GF(2^M) multiplier array scheduler.
//   M               field width of operands, polynomial and product
//   DEF_LAT         default array latency (arr_ctr pulse to valid arr_po)
//   DEF_ISSUE_GAP   default cycles between successive array start pulses
//   DEF_RBUF_DEPTH  default result buffer depth
//   AES_POLY        low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   state_t         issue FSM states
package gfmul_pkg;

  localparam int unsigned M              = 8;
  localparam int unsigned DEF_LAT        = 22;
  localparam int unsigned DEF_ISSUE_GAP  = 8;
  localparam int unsigned DEF_RBUF_DEPTH = 4;

  localparam logic [M-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/gfmul_rbuf.sv
// Result buffer: synchronous DEPTH x M FIFO with occupancy count.
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   clr    synchronous flush, priority over push/pop
//   push   write din at the tail
//   din    product to store
//   pop    discard the head entry
//   dout   head entry (meaningful only while count != 0)
//   count  number of stored entries, 0..DEPTH
module gfmul_rbuf
  import gfmul_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RBUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [M-1:0]               din,
  input  logic                       pop,
  output logic [M-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [M-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  // Issue credits make both of these unreachable.
  always_ff @(posedge clk) begin
    if (rst && !clr) begin
      if (push) assert (count < CW'(DEPTH));
      if (pop)  assert (count != '0);
    end
  end

endmodule

// File: rtl/gfmul_array_sched.sv
// Issue scheduler for the GF(2^M) systolic multiplier array.
// Accepts (a, b, g) triples, issues them to the array one per ISSUE_GAP
// cycles, tracks each op across the array latency, captures the product and
// returns products in order. Issue is credit-limited so that every op in
// flight is guaranteed a result buffer slot.
//   clk, rst          clock, asynchronous active-low reset
//   soft_clr          synchronous flush of FSM, tracker and buffer
//   in_valid/in_ready operand handshake; in_a, in_b, in_g operands
//   out_valid/ready   product handshake; out_p product
//   arr_ctr           array start strobe; arr_ai/bi/gi operand buses
//   arr_po            array product bus
//   busy              op issuing, in flight or buffered
module gfmul_array_sched
  import gfmul_pkg::*;
#(
  parameter int unsigned LAT        = DEF_LAT,
  parameter int unsigned ISSUE_GAP  = DEF_ISSUE_GAP,
  parameter int unsigned RBUF_DEPTH = DEF_RBUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         soft_clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  input  logic [M-1:0] in_g,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_p,
  output logic         arr_ctr,
  output logic [M-1:0] arr_ai,
  output logic [M-1:0] arr_bi,
  output logic [M-1:0] arr_gi,
  input  logic [M-1:0] arr_po,
  output logic         busy
);

  localparam int unsigned CW       = $clog2(RBUF_DEPTH + 1);
  localparam int unsigned GW       = $clog2(ISSUE_GAP + 1);
  localparam int unsigned GAP_LOAD = (ISSUE_GAP >= 2) ? ISSUE_GAP - 2 : 0;

  state_t        state;
  logic          started;
  logic [GW-1:0] gap_cnt;
  logic [LAT-1:0] trk;
  logic [CW-1:0] inflight_cnt;
  logic [CW-1:0] rbuf_cnt;
  logic [CW:0]   occupancy;
  logic [M-1:0]  rbuf_dout;
  logic          credit_ok;
  logic          last_slot;
  logic          accept;
  logic          push;
  logic          pop;

  // An op holds its credit from acceptance until it leaves the buffer:
  // counted in inflight_cnt until its tracker bit reaches the tail, then
  // handed to rbuf_cnt in the same cycle.
  assign occupancy = {1'b0, inflight_cnt} + {1'b0, rbuf_cnt};
  assign credit_ok = occupancy < (CW+1)'(RBUF_DEPTH);

  assign last_slot = ((state == ISSUE) && (ISSUE_GAP == 1)) ||
                     ((state == GAP) && (gap_cnt == '0));

  // started keeps in_ready low until the first edge after reset release.
  assign in_ready  = started && credit_ok && ((state == IDLE) || last_slot);
  assign accept    = in_valid && in_ready && !soft_clr;
  assign push      = trk[LAT-1];
  assign out_valid = (rbuf_cnt != '0);
  assign out_p     = out_valid ? rbuf_dout : '0;
  assign pop       = out_valid && out_ready && !soft_clr;
  assign busy      = (state != IDLE) || (inflight_cnt != '0) || (rbuf_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      started      <= 1'b0;
      gap_cnt      <= '0;
      trk          <= '0;
      inflight_cnt <= '0;
      arr_ctr      <= 1'b0;
      arr_ai       <= '0;
      arr_bi       <= '0;
      arr_gi       <= '0;
    end else begin
      started <= 1'b1;
      if (soft_clr) begin
        state        <= IDLE;
        gap_cnt      <= '0;
        trk          <= '0;
        inflight_cnt <= '0;
        arr_ctr      <= 1'b0;
        arr_ai       <= '0;
        arr_bi       <= '0;
        arr_gi       <= '0;
      end else begin
        arr_ctr <= accept;
        trk     <= (trk << 1) | LAT'(arr_ctr);

        case ({accept, push})
          2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
          2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
          default: inflight_cnt <= inflight_cnt;
        endcase

        // Accept is only possible in IDLE or in the last slot of an issue
        // window, so it is checked first and covers both.
        if (accept) begin
          state  <= ISSUE;
          arr_ai <= in_a;
          arr_bi <= in_b;
          arr_gi <= in_g;
        end else if (last_slot) begin
          state  <= IDLE;
          arr_ai <= '0;
          arr_bi <= '0;
          arr_gi <= '0;
        end else if (state == ISSUE) begin
          state   <= GAP;
          gap_cnt <= GW'(GAP_LOAD);
        end else if (state == GAP) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

  gfmul_rbuf #(
    .DEPTH (RBUF_DEPTH)
  ) u_rbuf (
    .clk   (clk),
    .rst   (rst),
    .clr   (soft_clr),
    .push  (push),
    .din   (arr_po),
    .pop   (pop),
    .dout  (rbuf_dout),
    .count (rbuf_cnt)
  );

endmodule

// File: tb/tb_gfmul_array_sched.sv
module tb_gfmul_array_sched;
  import gfmul_pkg::*;

  localparam int unsigned LAT        = 22;
  localparam int unsigned ISSUE_GAP  = 8;
  localparam int unsigned RBUF_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_g;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       arr_ctr;
  logic [7:0] arr_ai, arr_bi, arr_gi;
  logic [7:0] arr_po;
  logic       busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;

  logic [7:0]  got_q[$];
  int unsigned ctr_q[$];

  // Directed operand table with hand-computed products.
  logic [7:0] va [16];
  logic [7:0] vb [16];
  logic [7:0] vg [16];
  logic [7:0] vp [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gfmul_array_sched #(
    .LAT        (LAT),
    .ISSUE_GAP  (ISSUE_GAP),
    .RBUF_DEPTH (RBUF_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_clr  (soft_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_g      (in_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .arr_ctr   (arr_ctr),
    .arr_ai    (arr_ai),
    .arr_bi    (arr_bi),
    .arr_gi    (arr_gi),
    .arr_po    (arr_po),
    .busy      (busy)
  );

  // Behavioural array: product appears LAT cycles after the arr_ctr cycle;
  // every other slot carries filler so mistimed captures are visible.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] g);
    logic [7:0] p;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      p = p[7] ? ({p[6:0], 1'b0} ^ g) : {p[6:0], 1'b0};
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  logic [7:0] pipe [LAT];
  initial foreach (pipe[k]) pipe[k] = 8'hA5;
  always @(posedge clk) begin
    pipe[0] <= arr_ctr ? gf_ref(arr_ai, arr_bi, arr_gi) : 8'hA5;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign arr_po = pipe[LAT-1];

  always @(negedge clk) begin
    if (arr_ctr) ctr_q.push_back(cyc);
    if (out_valid && out_ready) got_q.push_back(out_p);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int unsigned n);
    while (cyc < n) tick;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                       output int unsigned t_acc, output bit ok);
    in_a = a; in_b = b; in_g = g; in_valid = 1'b1;
    ok = 1'b0;
    t_acc = cyc;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (in_ready) begin
        ok = 1'b1;
        t_acc = cyc;
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, arr_ctr, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctl got in_ready/out_valid/arr_ctr/busy=%b want 0000",
               {in_ready, out_valid, arr_ctr, busy});
    end
    vectors++;
    if ({arr_ai, arr_bi, arr_gi, out_p} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus got %h want 00000000", {arr_ai, arr_bi, arr_gi, out_p});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    tick;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_edge got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single;
    int unsigned t;
    bit ok;
    out_ready = 1'b1;
    got_q.delete();
    offer(8'h57, 8'h83, AES_POLY, t, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_accept got timeout want accept");
    end
    vectors++;
    if ({arr_ctr, arr_ai, arr_bi, arr_gi} !== {1'b1, 8'h57, 8'h83, 8'h1B}) begin
      miscompares++;
      $display("FAIL single_issue got %b %h %h %h want 1 57 83 1b", arr_ctr, arr_ai, arr_bi, arr_gi);
    end
    for (int k = 2; k <= int'(ISSUE_GAP); k++) begin
      tick;
      vectors++;
      if ({arr_ctr, arr_ai, arr_bi, arr_gi} !== {1'b0, 8'h57, 8'h83, 8'h1B}) begin
        miscompares++;
        $display("FAIL single_hold t+%0d got %b %h %h %h want 0 57 83 1b", k, arr_ctr,
                 arr_ai, arr_bi, arr_gi);
      end
    end
    tick;
    vectors++;
    if ({arr_ctr, arr_ai, arr_bi, arr_gi} !== 25'h0) begin
      miscompares++;
      $display("FAIL single_idle_bus got %b %h %h %h want 0 00 00 00", arr_ctr, arr_ai, arr_bi, arr_gi);
    end
    at_cycle(t + 1 + LAT);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early got out_valid=%b want 0", out_valid);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_p !== 8'hC1) begin
      miscompares++;
      $display("FAIL single_result got %b/%h want 1/c1", out_valid, out_p);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || got_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_drain got out_valid=%b busy=%b pops=%0d want 0 0 1", out_valid, busy,
               got_q.size());
    end
  endtask

  task automatic test_stream;
    int unsigned t;
    bit ok;
    logic [7:0] g;
    out_ready = 1'b1;
    got_q.delete();
    ctr_q.delete();
    for (int i = 0; i < 16; i++) begin
      offer(va[i], vb[i], vg[i], t, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL stream_accept op %0d got timeout want accept", i);
      end
    end
    for (int c = 0; c < 300 && got_q.size() < 16; c++) tick;
    vectors++;
    if (got_q.size() != 16 || ctr_q.size() != 16) begin
      miscompares++;
      $display("FAIL stream_count got %0d results %0d pulses want 16 16", got_q.size(), ctr_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++;
      if (g !== vp[i]) begin
        miscompares++;
        $display("FAIL stream_result %0d got %h want %h", i, g, vp[i]);
      end
    end
    for (int i = 0; i + 1 < ctr_q.size(); i++) begin
      vectors++;
      if (ctr_q[i+1] - ctr_q[i] != ISSUE_GAP) begin
        miscompares++;
        $display("FAIL stream_gap %0d got %0d want %0d", i, ctr_q[i+1] - ctr_q[i], ISSUE_GAP);
      end
    end
  endtask

  task automatic test_backpressure;
    int unsigned acc;
    bit take;
    logic [7:0] g;
    acc = 0;
    out_ready = 1'b0;
    got_q.delete();
    in_a = va[0]; in_b = vb[0]; in_g = vg[0]; in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      take = in_valid && in_ready;
      tick;
      if (take) begin
        acc++;
        in_a = va[acc]; in_b = vb[acc]; in_g = vg[acc];
      end
    end
    vectors++;
    if (acc != RBUF_DEPTH || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_credit got accepted=%0d in_ready=%b want %0d 0", acc, in_ready, RBUF_DEPTH);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_p !== vp[0] || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold got %b/%h busy=%b want 1/%h 1", out_valid, out_p, busy, vp[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 600 && !(acc == 10 && got_q.size() == 10 && busy === 1'b0); c++) begin
      take = in_valid && in_ready;
      tick;
      if (take) begin
        acc++;
        if (acc < 10) begin
          in_a = va[acc]; in_b = vb[acc]; in_g = vg[acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (acc != 10 || got_q.size() != 10) begin
      miscompares++;
      $display("FAIL bp_drain got accepted=%0d results=%0d want 10 10", acc, got_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++;
      if (g !== vp[i]) begin
        miscompares++;
        $display("FAIL bp_result %0d got %h want %h", i, g, vp[i]);
      end
    end
  endtask

  task automatic test_push_pop;
    int unsigned t1, t2;
    bit ok1, ok2;
    out_ready = 1'b0;
    got_q.delete();
    offer(8'h57, 8'h04, AES_POLY, t1, ok1);
    offer(8'h57, 8'h08, AES_POLY, t2, ok2);
    vectors++;
    if (!ok1 || !ok2 || t2 - t1 != ISSUE_GAP) begin
      miscompares++;
      $display("FAIL pp_accept got ok=%b%b spacing=%0d want 11 %0d", ok1, ok2, t2 - t1, ISSUE_GAP);
    end
    at_cycle(t2 + 1 + LAT);
    vectors++;
    if (out_valid !== 1'b1 || out_p !== 8'h47) begin
      miscompares++;
      $display("FAIL pp_head got %b/%h want 1/47", out_valid, out_p);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_p !== 8'h8E) begin
      miscompares++;
      $display("FAIL pp_after got %b/%h want 1/8e", out_valid, out_p);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b1 || out_p !== 8'h8E) begin
      miscompares++;
      $display("FAIL pp_stable got %b/%h want 1/8e", out_valid, out_p);
    end
    out_ready = 1'b1;
    tick;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pp_count got out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 8'h47 || got_q[1] !== 8'h8E) begin
      miscompares++;
      $display("FAIL pp_order got %0d results want 47,8e in order", got_q.size());
    end
  endtask

  task automatic test_soft_clr;
    int unsigned t1, t2, t3;
    bit ok1, ok2, ok3;
    int unsigned seen;
    seen = 0;
    out_ready = 1'b0;
    got_q.delete();
    offer(8'h57, 8'h01, AES_POLY, t1, ok1);
    offer(8'h57, 8'h02, AES_POLY, t2, ok2);
    offer(8'h57, 8'h04, AES_POLY, t3, ok3);
    at_cycle(t1 + 2 + LAT);
    vectors++;
    if (!ok1 || !ok2 || !ok3 || out_valid !== 1'b1 || out_p !== 8'h57) begin
      miscompares++;
      $display("FAIL clr_setup got ok=%b%b%b %b/%h want 111 1/57", ok1, ok2, ok3, out_valid, out_p);
    end
    soft_clr = 1'b1;
    tick;
    soft_clr = 1'b0;
    vectors++;
    if ({out_valid, busy, arr_ctr, in_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL clr_next got out_valid/busy/arr_ctr/in_ready=%b want 0001",
               {out_valid, busy, arr_ctr, in_ready});
    end
    out_ready = 1'b1;
    for (int c = 0; c < int'(LAT) + 4; c++) begin
      tick;
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL clr_stale got %0d valid cycles %0d pops want 0 0", seen, got_q.size());
    end
  endtask

  task automatic test_async_reset;
    int unsigned ta, tb, t;
    bit ok;
    out_ready = 1'b0;
    got_q.delete();
    offer(8'h57, 8'h10, AES_POLY, ta, ok);
    at_cycle(ta + 2 + LAT);
    vectors++;
    if (!ok || out_valid !== 1'b1 || out_p !== 8'h07) begin
      miscompares++;
      $display("FAIL arst_setup got ok=%b %b/%h want 1 1/07", ok, out_valid, out_p);
    end
    offer(8'h57, 8'h13, AES_POLY, tb, ok);
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, arr_ctr, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL arst_ctl got in_ready/out_valid/arr_ctr/busy=%b want 0000",
               {in_ready, out_valid, arr_ctr, busy});
    end
    vectors++;
    if ({arr_ai, arr_bi, arr_gi, out_p} !== 32'h0) begin
      miscompares++;
      $display("FAIL arst_bus got %h want 00000000", {arr_ai, arr_bi, arr_gi, out_p});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_release got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    out_ready = 1'b1;
    offer(8'h02, 8'h87, AES_POLY, t, ok);
    at_cycle(t + 2 + LAT);
    vectors++;
    if (!ok || out_valid !== 1'b1 || out_p !== 8'h15) begin
      miscompares++;
      $display("FAIL arst_result got ok=%b %b/%h want 1 1/15", ok, out_valid, out_p);
    end
    for (int c = 0; c < int'(LAT) + 4; c++) tick;
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h15 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_stale got %0d pops busy=%b want 1 pop of 15, busy 0", got_q.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_g = '0;
    va = '{8'h57, 8'h57, 8'h57, 8'h57, 8'h57, 8'h57, 8'h57, 8'h02,
           8'h83, 8'h13, 8'h00, 8'hFF, 8'h87, 8'h80, 8'h01, 8'h02};
    vb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h13, 8'h83, 8'h87,
           8'h57, 8'h57, 8'hFF, 8'h01, 8'h02, 8'h02, 8'h01, 8'h80};
    vg = '{8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B,
           8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1D};
    vp = '{8'h57, 8'hAE, 8'h47, 8'h8E, 8'h07, 8'hFE, 8'hC1, 8'h15,
           8'hC1, 8'hFE, 8'h00, 8'hFF, 8'h15, 8'h1B, 8'h01, 8'h1D};
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_push_pop;
    test_soft_clr;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
